// File: rtl/tdnn_layer_sequencer.sv
// Sequencer for one TDNN layer: serial weight/bias programming of each neuron,
// tap-line shifting of input samples, and valid/ready capture of neuron results.
module tdnn_layer_sequencer #(
  parameter int SIG_SIZE      = 16,
  parameter int WEIGHT_SIZE   = 16,
  parameter int ADDITION_SIZE = 20,
  parameter int NUM_INPUTS    = 3,
  parameter int NUM_NEURONS   = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                               CLOCK_N,
  input  logic                               RESET_N,
  input  logic                               CFG_START,
  input  logic                               CFG_VALID,
  output logic                               CFG_READY,
  input  logic [WEIGHT_SIZE-1:0]             CFG_DATA,
  output logic                               CFG_DONE,
  input  logic                               SAMPLE_VALID,
  output logic                               SAMPLE_READY,
  input  logic [SIG_SIZE-1:0]                SAMPLE_IN,
  output logic [NUM_INPUTS*SIG_SIZE-1:0]     TAP_OUT,
  output logic [NUM_NEURONS-1:0]             WB_EN,
  output logic [NUM_INPUTS*WEIGHT_SIZE-1:0]  WEIGHTS_OUT,
  output logic [WEIGHT_SIZE-1:0]             BIAS_OUT,
  input  logic [NUM_NEURONS*ADDITION_SIZE-1:0] NEURON_RESULT,
  output logic                               OUT_VALID,
  input  logic                               OUT_READY,
  output logic [NUM_NEURONS*ADDITION_SIZE-1:0] OUT_DATA,
  output logic                               BUSY
);

  localparam int WW = $clog2(NUM_INPUTS + 1);
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [WW-1:0] WORD_BIAS   = WW'(NUM_INPUTS);
  localparam logic [NW-1:0] NEURON_LAST = NW'(NUM_NEURONS - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PROGRAM,
    S_SETTLE,
    S_HOLD
  } state_t;

  state_t                                     state_q;
  logic [WW-1:0]                              word_idx_q;
  logic [NW-1:0]                              neuron_idx_q;
  logic [SW-1:0]                              settle_cnt_q;
  logic [NUM_INPUTS-1:0][WEIGHT_SIZE-1:0]     wstage_q;
  logic [WEIGHT_SIZE-1:0]                     bias_q;
  logic [NUM_NEURONS-1:0]                     wb_en_q;
  logic                                       cfg_done_q;
  logic [NUM_INPUTS-1:0][SIG_SIZE-1:0]        tap_q;
  logic [NUM_NEURONS*ADDITION_SIZE-1:0]       out_data_q;
  logic                                       out_valid_q;

  // All state advances on the falling edge so it lines up with the neuron datapath.
  always_ff @(negedge CLOCK_N or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      word_idx_q   <= '0;
      neuron_idx_q <= '0;
      settle_cnt_q <= '0;
      wstage_q     <= '0;
      bias_q       <= '0;
      wb_en_q      <= '0;
      cfg_done_q   <= 1'b0;
      tap_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (CFG_START) begin
            state_q      <= S_LOAD;
            cfg_done_q   <= 1'b0;
            neuron_idx_q <= '0;
            word_idx_q   <= '0;
          end else if (SAMPLE_VALID && cfg_done_q) begin
            for (int unsigned i = 1; i < NUM_INPUTS; i++) begin
              tap_q[i] <= tap_q[i-1];
            end
            tap_q[0]     <= SAMPLE_IN;
            settle_cnt_q <= SETTLE_LOAD;
            state_q      <= S_SETTLE;
          end
        end
        S_LOAD: begin
          if (CFG_VALID) begin
            if (word_idx_q == WORD_BIAS) begin
              bias_q  <= CFG_DATA;
              wb_en_q <= NUM_NEURONS'(1) << neuron_idx_q;
              state_q <= S_PROGRAM;
            end else begin
              for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                if (word_idx_q == WW'(i)) begin
                  wstage_q[i] <= CFG_DATA;
                end
              end
              word_idx_q <= word_idx_q + 1'b1;
            end
          end
        end
        S_PROGRAM: begin
          wb_en_q <= '0;
          if (neuron_idx_q == NEURON_LAST) begin
            cfg_done_q <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            neuron_idx_q <= neuron_idx_q + 1'b1;
            word_idx_q   <= '0;
            state_q      <= S_LOAD;
          end
        end
        S_SETTLE: begin
          if (settle_cnt_q == '0) begin
            out_data_q  <= NEURON_RESULT;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end else begin
            settle_cnt_q <= settle_cnt_q - 1'b1;
          end
        end
        S_HOLD: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign CFG_READY    = (state_q == S_LOAD);
  assign SAMPLE_READY = (state_q == S_IDLE) && cfg_done_q;
  assign BUSY         = (state_q != S_IDLE);
  assign CFG_DONE     = cfg_done_q;
  assign WB_EN        = wb_en_q;
  assign WEIGHTS_OUT  = wstage_q;
  assign BIAS_OUT     = bias_q;
  assign TAP_OUT      = tap_q;
  assign OUT_DATA     = out_data_q;
  assign OUT_VALID    = out_valid_q;

endmodule

// File: tb/tb_tdnn_layer_sequencer.sv
// Randomized bench for tdnn_layer_sequencer against a transaction-level model
// of configuration words, tap history and captured results.
module tb_tdnn_layer_sequencer;

  localparam int SS = 16;
  localparam int WS = 16;
  localparam int AS = 20;
  localparam int NI = 3;
  localparam int NN = 2;
  localparam int SC = 2;
  localparam int NWORDS = NN * (NI + 1);

  logic                 CLOCK_N;
  logic                 RESET_N;
  logic                 CFG_START;
  logic                 CFG_VALID;
  logic                 CFG_READY;
  logic [WS-1:0]        CFG_DATA;
  logic                 CFG_DONE;
  logic                 SAMPLE_VALID;
  logic                 SAMPLE_READY;
  logic [SS-1:0]        SAMPLE_IN;
  logic [NI*SS-1:0]     TAP_OUT;
  logic [NN-1:0]        WB_EN;
  logic [NI*WS-1:0]     WEIGHTS_OUT;
  logic [WS-1:0]        BIAS_OUT;
  logic [NN*AS-1:0]     NEURON_RESULT;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic [NN*AS-1:0]     OUT_DATA;
  logic                 BUSY;

  tdnn_layer_sequencer #(
    .SIG_SIZE      (SS),
    .WEIGHT_SIZE   (WS),
    .ADDITION_SIZE (AS),
    .NUM_INPUTS    (NI),
    .NUM_NEURONS   (NN),
    .SETTLE_CYCLES (SC)
  ) dut (
    .CLOCK_N       (CLOCK_N),
    .RESET_N       (RESET_N),
    .CFG_START     (CFG_START),
    .CFG_VALID     (CFG_VALID),
    .CFG_READY     (CFG_READY),
    .CFG_DATA      (CFG_DATA),
    .CFG_DONE      (CFG_DONE),
    .SAMPLE_VALID  (SAMPLE_VALID),
    .SAMPLE_READY  (SAMPLE_READY),
    .SAMPLE_IN     (SAMPLE_IN),
    .TAP_OUT       (TAP_OUT),
    .WB_EN         (WB_EN),
    .WEIGHTS_OUT   (WEIGHTS_OUT),
    .BIAS_OUT      (BIAS_OUT),
    .NEURON_RESULT (NEURON_RESULT),
    .OUT_VALID     (OUT_VALID),
    .OUT_READY     (OUT_READY),
    .OUT_DATA      (OUT_DATA),
    .BUSY          (BUSY)
  );

  initial CLOCK_N = 1'b1;
  always #5 CLOCK_N = ~CLOCK_N;

  int            n_vec = 0;
  int            n_err = 0;
  logic [WS-1:0] cfg_w [NWORDS];
  logic [SS-1:0] tapq [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_N);
    #1;
  endtask

  function automatic logic [63:0] exp_taps();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NI; i++) begin
      if (i < tapq.size()) r[i*SS +: SS] = tapq[i];
    end
    return r;
  endfunction

  task automatic randomize_cfg();
    for (int i = 0; i < NWORDS; i++) cfg_w[i] = WS'($urandom);
  endtask

  // Asynchronous reset applied between edges; outputs must clear with no clock.
  task automatic do_reset();
    #2;
    RESET_N      = 1'b0;
    CFG_START    = 1'b0;
    CFG_VALID    = 1'b0;
    SAMPLE_VALID = 1'b0;
    OUT_READY    = 1'b0;
    #1;
    check("rst_cfg_done", 64'(CFG_DONE), 64'(0));
    check("rst_wb_en",    64'(WB_EN), 64'(0));
    check("rst_tap",      64'(TAP_OUT), 64'(0));
    check("rst_out_data", 64'(OUT_DATA), 64'(0));
    check("rst_out_vld",  64'(OUT_VALID), 64'(0));
    check("rst_weights",  64'(WEIGHTS_OUT), 64'(0));
    check("rst_bias",     64'(BIAS_OUT), 64'(0));
    check("rst_busy",     64'(BUSY), 64'(0));
    check("rst_cfg_rdy",  64'(CFG_READY), 64'(0));
    check("rst_smp_rdy",  64'(SAMPLE_READY), 64'(0));
    #1;
    RESET_N = 1'b1;
    tick();
    tapq.delete();
    check("post_rst_busy", 64'(BUSY), 64'(0));
    check("post_rst_srdy", 64'(SAMPLE_READY), 64'(0));
  endtask

  // gap < 0 selects a random 0..3 cycle CFG_VALID gap before each word.
  task automatic cfg_load(input bit do_start, input int gap);
    logic [63:0] ew;
    int          g;
    if (do_start) begin
      CFG_START = 1'b1;
      tick();
      CFG_START = 1'b0;
    end
    check("cfg_ready", 64'(CFG_READY), 64'(1));
    check("cfg_done_clr", 64'(CFG_DONE), 64'(0));
    for (int k = 0; k < NN; k++) begin
      ew = '0;
      for (int j = 0; j <= NI; j++) begin
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        CFG_VALID = 1'b0;
        for (int c = 0; c < g; c++) begin
          tick();
          check("stall_ready", 64'(CFG_READY), 64'(1));
          check("stall_wb_en", 64'(WB_EN), 64'(0));
        end
        CFG_VALID = 1'b1;
        CFG_DATA  = cfg_w[k*(NI+1)+j];
        if (j < NI) ew[j*WS +: WS] = cfg_w[k*(NI+1)+j];
        tick();
      end
      if (gap == 0 && k < NN - 1) begin
        CFG_VALID = 1'b1;
        CFG_DATA  = cfg_w[(k+1)*(NI+1)];
      end else begin
        CFG_VALID = 1'b0;
      end
      check("wb_en", 64'(WB_EN), 64'(1) << k);
      check("weights", 64'(WEIGHTS_OUT), ew);
      check("bias", 64'(BIAS_OUT), 64'(cfg_w[k*(NI+1)+NI]));
      check("prog_ready", 64'(CFG_READY), 64'(0));
      tick();
      check("wb_en_off", 64'(WB_EN), 64'(0));
      check("weights_hold", 64'(WEIGHTS_OUT), ew);
      check("bias_hold", 64'(BIAS_OUT), 64'(cfg_w[k*(NI+1)+NI]));
    end
    CFG_VALID = 1'b0;
    check("cfg_done", 64'(CFG_DONE), 64'(1));
    check("cfg_idle", 64'(BUSY), 64'(0));
    check("cfg_srdy", 64'(SAMPLE_READY), 64'(1));
  endtask

  task automatic send_sample(input logic [SS-1:0] s, input bit pulse_start,
                             input bit rst_in_hold, input int hold_cycles);
    logic [63:0] nr;
    logic [63:0] exp_out;
    int          lat;
    check("smp_ready", 64'(SAMPLE_READY), 64'(1));
    SAMPLE_VALID = 1'b1;
    SAMPLE_IN    = s;
    OUT_READY    = 1'b0;
    tick();
    SAMPLE_VALID = 1'b0;
    tapq.push_front(s);
    if (tapq.size() > NI) void'(tapq.pop_back());
    check("tap", 64'(TAP_OUT), exp_taps());
    check("settle_srdy", 64'(SAMPLE_READY), 64'(0));
    check("settle_busy", 64'(BUSY), 64'(1));
    check("ovalid_early", 64'(OUT_VALID), 64'(0));
    lat = 0;
    exp_out = '0;
    for (int e = 1; e <= 20 && lat == 0; e++) begin
      nr = {$urandom, $urandom};
      NEURON_RESULT = nr[NN*AS-1:0];
      if (pulse_start && e == 1) CFG_START = 1'b1;
      tick();
      CFG_START = 1'b0;
      if (OUT_VALID) begin
        lat = e;
        exp_out = 64'(nr[NN*AS-1:0]);
      end
    end
    check("latency", 64'(lat), 64'(SC));
    check("out_data", 64'(OUT_DATA), exp_out);
    if (pulse_start) begin
      check("start_ignored_rdy", 64'(CFG_READY), 64'(0));
      check("start_ignored_done", 64'(CFG_DONE), 64'(1));
    end
    for (int c = 0; c < hold_cycles; c++) begin
      NEURON_RESULT = NN*AS'({$urandom, $urandom});
      tick();
      check("hold_valid", 64'(OUT_VALID), 64'(1));
      check("hold_data", 64'(OUT_DATA), exp_out);
      check("hold_srdy", 64'(SAMPLE_READY), 64'(0));
    end
    if (rst_in_hold) begin
      do_reset();
    end else begin
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      check("release_valid", 64'(OUT_VALID), 64'(0));
      check("release_srdy", 64'(SAMPLE_READY), 64'(1));
      check("release_busy", 64'(BUSY), 64'(0));
    end
  endtask

  logic [63:0] saved_tap;

  initial begin
    RESET_N       = 1'b1;
    CFG_START     = 1'b0;
    CFG_VALID     = 1'b0;
    CFG_DATA      = '0;
    SAMPLE_VALID  = 1'b0;
    SAMPLE_IN     = '0;
    NEURON_RESULT = '0;
    OUT_READY     = 1'b0;
    tick();
    do_reset();

    cfg_w = '{16'h1000, 16'h2000, 16'h3000, 16'h0100,
              16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF};
    cfg_load(1'b1, 0);
    cfg_load(1'b1, 3);

    send_sample(16'h0001, 1'b0, 1'b0, 0);
    send_sample(16'h0002, 1'b0, 1'b0, 5);
    send_sample(16'h0003, 1'b0, 1'b0, 1);
    check("tap_123", 64'(TAP_OUT), 64'h0000_0001_0002_0003);

    saved_tap    = 64'(TAP_OUT);
    CFG_START    = 1'b1;
    SAMPLE_VALID = 1'b1;
    SAMPLE_IN    = 16'h5555;
    tick();
    CFG_START    = 1'b0;
    SAMPLE_VALID = 1'b0;
    check("coll_tap", 64'(TAP_OUT), saved_tap);
    randomize_cfg();
    cfg_load(1'b0, -1);
    send_sample(SS'($urandom), 1'b1, 1'b0, 2);

    for (int it = 0; it < 20; it++) begin
      if (it % 7 == 6) begin
        randomize_cfg();
        cfg_load(1'b1, -1);
      end
      send_sample(SS'($urandom), 1'($urandom_range(0, 1)), 1'b0,
                  int'($urandom_range(0, 5)));
    end

    CFG_START = 1'b1;
    tick();
    CFG_START = 1'b0;
    CFG_VALID = 1'b1;
    CFG_DATA  = 16'hA5A5;
    tick();
    CFG_DATA  = 16'h5A5A;
    tick();
    CFG_VALID = 1'b0;
    do_reset();
    randomize_cfg();
    cfg_load(1'b1, -1);
    send_sample(SS'($urandom), 1'b0, 1'b0, 0);

    send_sample(SS'($urandom), 1'b0, 1'b1, 2);
    randomize_cfg();
    cfg_load(1'b1, -1);
    send_sample(SS'($urandom), 1'b0, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
